// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch (F) stage and IF/ID pipeline register.
//
// The block holds the fetch PC, selects the next PC and registers the fetched
// instruction for decode. Redirects are decoded in D. There is no F/D flush:
// the instruction already in F is the delay slot and always enters D.
//
// Parameters
//   RESET_PC  first fetch address after reset
//   IM_WORDS  instruction-memory depth in 32-bit words
//
// Ports
//   clk        clock; all state changes on the rising edge
//   reset      synchronous, active-high; overrides stall and npc_sel
//   stall      holds F_PC and the IF/ID register
//   npc_sel    next-PC source: 0 sequential, 1 branch, 2 j/jal, 3 jr/jalr
//   rs_val     forwarded GPR[rs], the jr/jalr target
//   F_PC       current fetch address, driven to instruction memory
//   IM_Instr   instruction returned combinationally for F_PC
//   D_Instr    instruction presented to decode
//   D_PC       address of D_Instr
//   D_PC8      D_PC + 8, the jal/jalr link value
//   fetch_err  sticky bad-fetch flag
//
// Optional feature: define FETCH_ADDR_CHK_EN to check each fetch address.
// A fetch is bad if it is misaligned or outside
// [RESET_PC, RESET_PC + 4*IM_WORDS). A bad fetch enters decode as a nop and
// sets fetch_err, which stays set until reset. Without the macro, fetch_err
// is tied to 0 and IM_Instr passes to decode unchanged.

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] rs_val,
  output logic [31:0] F_PC,
  input  logic [31:0] IM_Instr,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic [31:0] D_PC8,
  output logic        fetch_err
);

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  logic        [31:0] pc_p0;
  logic        [31:0] npc_p0;
  logic        [31:0] instr_p0;
  logic signed [31:0] br_off_p0;

  logic        [31:0] instr_p1;
  logic        [31:0] pc_p1;
  logic        [31:0] pc8_p1;

  // Branch offset: sign-extended 16-bit immediate scaled to bytes.
  function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
    logic signed [31:0] ext;
    ext = {{16{imm[15]}}, imm};
    return ext <<< 2;
  endfunction

  assign br_off_p0 = branch_offset(instr_p1[15:0]);

  // Redirect targets use the instruction sitting in D, so a redirect takes
  // effect on the fetch after the delay slot already in F.
  always_comb begin
    npc_p0 = pc_p0 + 32'd4;
    unique case (npc_sel)
      NPC_SEQ: npc_p0 = pc_p0 + 32'd4;
      NPC_BR:  npc_p0 = pc_p1 + 32'd4 + $unsigned(br_off_p0);
      NPC_J:   npc_p0 = {pc_p1[31:28], instr_p1[25:0], 2'b00};
      NPC_JR:  npc_p0 = rs_val;
      default: npc_p0 = pc_p0 + 32'd4;
    endcase
  end

`ifdef FETCH_ADDR_CHK_EN
  // Upper bound kept at 33 bits so a region ending at 2^32 does not wrap.
  localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);

  logic bad_p0;
  logic err_p1;

  assign bad_p0 = (pc_p0[1:0] != 2'b00) ||
                  (pc_p0 < RESET_PC) ||
                  ({1'b0, pc_p0} >= PC_LIMIT);

  assign instr_p0 = bad_p0 ? 32'h0000_0000 : IM_Instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_p1 <= 1'b0;
    end else if (!stall && bad_p0) begin
      err_p1 <= 1'b1;
    end
  end

  assign fetch_err = err_p1;
`else
  assign instr_p0  = IM_Instr;
  assign fetch_err = 1'b0;
`endif

  // ---- F stage: fetch PC register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0 <= RESET_PC;
    end else if (!stall) begin
      pc_p0 <= npc_p0;
    end
  end

  // ---- IF/ID boundary: decode-side registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_p1 <= 32'h0000_0000;
      pc_p1    <= 32'h0000_0000;
      pc8_p1   <= 32'h0000_0000;
    end else if (!stall) begin
      instr_p1 <= instr_p0;
      pc_p1    <= pc_p0;
      pc8_p1   <= pc_p0 + 32'd8;
    end
  end

  assign F_PC    = pc_p0;
  assign D_Instr = instr_p1;
  assign D_PC    = pc_p1;
  assign D_PC8   = pc8_p1;

endmodule
